hex_segment_reader: RTL and testbench

- Decodes a 7-segment pattern back into its 4-bit hex value, exactly reversing the team's hex_display encoding.
- Used as a loopback/self-check monitor on the HEX0/HEX2/HEX4/HEX5 display buses of the ALU board design.
- A pattern must be stable for a programmable number of clock cycles before it is reported.
- Each stable pattern produces exactly one report: a valid hex value, a blank display, or an illegal pattern (counted).

---
 rtl/hex_segment_reader.sv | 122 ++++++++++++
 tb/tb_hex_segment_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_segment_reader.sv
// Loopback monitor for a 7-segment display bus: waits for a pattern to hold
// for STABLE_CYCLES edges, then reports it once as a digit, a blank, or an error.
module hex_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] Display,
  output logic [3:0] Value,
  output logic       value_valid,
  output logic       bad_pattern,
  output logic       blank,
  output logic       locked,
  output logic [7:0] err_count
);

  // state    | meaning
  // SETTLING | pattern changed recently, stability counter running
  // LOCKED   | current pattern reported, holding until it changes
  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [7:0] NCYC = STABLE_CYCLES[7:0];
  localparam logic [6:0] BLANK_CODE = 7'h7F;

  state_t     state_q, state_d;
  logic [6:0] seg_q;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       changed;
  logic       report;
  logic       dig_legal;
  logic [3:0] dig_val;
  logic       is_blank;

  // Inverse of the hex_display encoder, segments active-low.
  always_comb begin
    dig_legal = 1'b1;
    dig_val   = 4'h0;
    case (Display)
      7'h40: dig_val = 4'h0;
      7'h79: dig_val = 4'h1;
      7'h24: dig_val = 4'h2;
      7'h30: dig_val = 4'h3;
      7'h19: dig_val = 4'h4;
      7'h12: dig_val = 4'h5;
      7'h02: dig_val = 4'h6;
      7'h78: dig_val = 4'h7;
      7'h00: dig_val = 4'h8;
      7'h18: dig_val = 4'h9;
      7'h08: dig_val = 4'hA;
      7'h03: dig_val = 4'hB;
      7'h46: dig_val = 4'hC;
      7'h21: dig_val = 4'hD;
      7'h06: dig_val = 4'hE;
      7'h0E: dig_val = 4'hF;
      default: dig_legal = 1'b0;
    endcase
  end

  assign is_blank = (Display == BLANK_CODE);

  // cnt == 0 only right after reset; treat it as a fresh pattern.
  assign changed = (Display != seg_q) || (cnt_q == 8'd0);
  assign cnt_inc = (cnt_q >= NCYC) ? NCYC : cnt_q + 8'd1;
  assign cnt_d   = changed ? 8'd1 : cnt_inc;
  // A saturated counter means this run was already reported.
  assign report  = (cnt_d == NCYC) && (changed || (cnt_q != NCYC));

  always_comb begin
    state_d = state_q;
    if (report) begin
      state_d = LOCKED;
    end else if (changed) begin
      state_d = SETTLING;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= SETTLING;
    end else begin
      state_q <= state_d;
    end
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      seg_q       <= BLANK_CODE;
      cnt_q       <= 8'd0;
      Value       <= 4'h0;
      value_valid <= 1'b0;
      bad_pattern <= 1'b0;
      blank       <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      seg_q       <= Display;
      cnt_q       <= cnt_d;
      value_valid <= 1'b0;
      bad_pattern <= 1'b0;
      if (report) begin
        if (dig_legal) begin
          Value       <= dig_val;
          value_valid <= 1'b1;
          blank       <= 1'b0;
        end else if (is_blank) begin
          blank <= 1'b1;
        end else begin
          bad_pattern <= 1'b1;
          blank       <= 1'b0;
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_segment_reader.sv
// Directed bench for hex_segment_reader with STABLE_CYCLES = 4.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_hex_segment_reader;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Display = 7'h7F;
  logic [3:0] Value;
  logic       value_valid;
  logic       bad_pattern;
  logic       blank;
  logic       locked;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  hex_segment_reader #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .Display     (Display),
    .Value       (Value),
    .value_valid (value_valid),
    .bad_pattern (bad_pattern),
    .blank       (blank),
    .locked      (locked),
    .err_count   (err_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One rising edge, then land on the falling edge; pulses must stay exclusive.
  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("pulse_exclusive", {31'd0, value_valid & bad_pattern}, 32'd0);
  endtask

  typedef struct {
    logic [6:0] disp;
    logic [3:0] value;
    logic [1:0] kind;   // 0 digit, 1 blank, 2 illegal
  } vec_t;

  vec_t vecs[18];

  logic [3:0] exp_value;
  logic       exp_blank;
  logic [7:0] exp_err;
  int         bad_pulses;

  initial begin
    vecs[0]  = '{7'h40, 4'h0, 2'd0};
    vecs[1]  = '{7'h79, 4'h1, 2'd0};
    vecs[2]  = '{7'h24, 4'h2, 2'd0};
    vecs[3]  = '{7'h30, 4'h3, 2'd0};
    vecs[4]  = '{7'h19, 4'h4, 2'd0};
    vecs[5]  = '{7'h12, 4'h5, 2'd0};
    vecs[6]  = '{7'h02, 4'h6, 2'd0};
    vecs[7]  = '{7'h78, 4'h7, 2'd0};
    vecs[8]  = '{7'h00, 4'h8, 2'd0};
    vecs[9]  = '{7'h18, 4'h9, 2'd0};
    vecs[10] = '{7'h08, 4'hA, 2'd0};
    vecs[11] = '{7'h03, 4'hB, 2'd0};
    vecs[12] = '{7'h46, 4'hC, 2'd0};
    vecs[13] = '{7'h21, 4'hD, 2'd0};
    vecs[14] = '{7'h06, 4'hE, 2'd0};
    vecs[15] = '{7'h0E, 4'hF, 2'd0};
    vecs[16] = '{7'h7F, 4'h0, 2'd1};
    vecs[17] = '{7'h55, 4'h0, 2'd2};

    // Reset state
    @(negedge CLOCK_50);
    tick();
    tick();
    check("rst_value", {28'd0, Value}, 32'h0);
    check("rst_valid", {31'd0, value_valid}, 32'd0);
    check("rst_bad", {31'd0, bad_pattern}, 32'd0);
    check("rst_blank", {31'd0, blank}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);

    // First report latency: 0x24 at four edges
    reset = 1'b0;
    Display = 7'h24;
    repeat (3) begin
      tick();
      check("first_no_pulse", {31'd0, value_valid}, 32'd0);
      check("first_not_locked", {31'd0, locked}, 32'd0);
    end
    tick();
    check("first_valid", {31'd0, value_valid}, 32'd1);
    check("first_value", {28'd0, Value}, 32'h2);
    check("first_locked", {31'd0, locked}, 32'd1);
    check("first_err", {24'd0, err_count}, 32'd0);

    // Holding produces no further reports
    repeat (20) begin
      tick();
      check("hold_no_pulse", {31'd0, value_valid}, 32'd0);
      check("hold_locked", {31'd0, locked}, 32'd1);
      check("hold_value", {28'd0, Value}, 32'h2);
    end

    // Table sweep: all digits, then blank, then an illegal code
    exp_value = 4'h2;
    exp_blank = 1'b0;
    exp_err   = 8'd0;
    for (int i = 0; i < 18; i++) begin
      Display = vecs[i].disp;
      repeat (3) begin
        tick();
        check("vec_settle_valid", {31'd0, value_valid}, 32'd0);
        check("vec_settle_bad", {31'd0, bad_pattern}, 32'd0);
        check("vec_settle_locked", {31'd0, locked}, 32'd0);
      end
      tick();
      case (vecs[i].kind)
        2'd0: begin exp_value = vecs[i].value; exp_blank = 1'b0; end
        2'd1: exp_blank = 1'b1;
        default: begin exp_blank = 1'b0; exp_err = exp_err + 8'd1; end
      endcase
      check("vec_valid", {31'd0, value_valid}, {31'd0, vecs[i].kind == 2'd0});
      check("vec_bad", {31'd0, bad_pattern}, {31'd0, vecs[i].kind == 2'd2});
      check("vec_value", {28'd0, Value}, {28'd0, exp_value});
      check("vec_blank", {31'd0, blank}, {31'd0, exp_blank});
      check("vec_locked", {31'd0, locked}, 32'd1);
      check("vec_err", {24'd0, err_count}, {24'd0, exp_err});
      repeat (2) begin
        tick();
        check("vec_hold_valid", {31'd0, value_valid}, 32'd0);
        check("vec_hold_bad", {31'd0, bad_pattern}, 32'd0);
        check("vec_hold_locked", {31'd0, locked}, 32'd1);
      end
    end

    // Glitch: locked 0x79, two edges of 0x00, then back
    Display = 7'h79;
    repeat (3) tick();
    tick();
    check("glitch_pre_valid", {31'd0, value_valid}, 32'd1);
    check("glitch_pre_value", {28'd0, Value}, 32'h1);
    Display = 7'h00;
    repeat (2) begin
      tick();
      check("glitch_locked", {31'd0, locked}, 32'd0);
      check("glitch_no_pulse", {31'd0, value_valid}, 32'd0);
    end
    Display = 7'h79;
    repeat (3) begin
      tick();
      check("glitch_ret_no_pulse", {31'd0, value_valid}, 32'd0);
    end
    tick();
    check("glitch_ret_valid", {31'd0, value_valid}, 32'd1);
    check("glitch_ret_value", {28'd0, Value}, 32'h1);
    check("glitch_ret_locked", {31'd0, locked}, 32'd1);

    // Error counter saturation
    bad_pulses = 0;
    exp_err = 8'd1;
    for (int i = 0; i < 300; i++) begin
      Display = (i % 2 == 0) ? 7'h55 : 7'h2A;
      repeat (4) begin
        tick();
        if (bad_pattern) bad_pulses++;
      end
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
    check("sat_err", {24'd0, err_count}, {24'd0, exp_err});
    check("sat_err_255", {24'd0, err_count}, 32'd255);
    check("sat_pulses", bad_pulses, 32'd300);
    check("sat_value", {28'd0, Value}, 32'h1);

    // Reset in the middle of a pending report
    Display = 7'h55;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, value_valid}, 32'd0);
    check("mid_rst_bad", {31'd0, bad_pattern}, 32'd0);
    check("mid_rst_value", {28'd0, Value}, 32'h0);
    check("mid_rst_blank", {31'd0, blank}, 32'd0);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_err", {24'd0, err_count}, 32'd0);

    // Change on the edge that would report: change wins
    reset = 1'b0;
    Display = 7'h40;
    repeat (3) begin
      tick();
      check("race_settle", {31'd0, value_valid}, 32'd0);
    end
    Display = 7'h79;
    tick();
    check("race_no_report", {31'd0, value_valid}, 32'd0);
    check("race_not_locked", {31'd0, locked}, 32'd0);
    check("race_value_kept", {28'd0, Value}, 32'h0);
    repeat (2) begin
      tick();
      check("race_resettle", {31'd0, value_valid}, 32'd0);
    end
    tick();
    check("race_valid", {31'd0, value_valid}, 32'd1);
    check("race_value", {28'd0, Value}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
